// File: rtl/bcd_entry_if.sv
// Board-side bundle for the BCD entry controller: raw key/switch inputs
// towards the controller, committed/shadow values and display controls back.
interface bcd_entry_if;
  logic        enter_n;
  logic [3:0]  digit_in;
  logic [11:0] value_out;
  logic [11:0] shadow_out;
  logic        value_valid;
  logic        abort;
  logic        digit_err;
  logic [1:0]  input_state;
  logic        disp_mode;
  logic [3:0]  seg_en;

  // Controller side
  modport slave (
    input  enter_n, digit_in,
    output value_out, shadow_out, value_valid, abort, digit_err,
           input_state, disp_mode, seg_en
  );

  // Board / display side
  modport master (
    output enter_n, digit_in,
    input  value_out, shadow_out, value_valid, abort, digit_err,
           input_state, disp_mode, seg_en
  );
endinterface

// File: rtl/bcd_entry_ctrl.sv
// Three-digit BCD entry sequencer: synchronizes and debounces the enter key,
// steps ones/tens/hundreds into a shadow register, commits to value_out,
// aborts on idle timeout and drives display mode / blinking digit enables.
module bcd_entry_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BLINK_HALF      = 12500000,
  parameter int TIMEOUT_CYCLES  = 500000000
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  bcd_entry_if.slave bus
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, D0 = 2'd1, D1 = 2'd2, D2 = 2'd3} state_e;

  logic          sync1_q, sync1_d, sync2_q, sync2_d;
  logic          deb_q, deb_d, enter_q, enter_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  state_e        state_q, state_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [BW-1:0] blk_cnt_q, blk_cnt_d;
  logic          blink_q, blink_d;
  logic [11:0]   shadow_q, shadow_d, value_q, value_d;
  logic          valid_q, valid_d, abort_q, abort_d, err_q, err_d;
  logic          disp_q, disp_d;
  logic [3:0]    seg_q, seg_d;
  logic          digit_ok, to_hit;

  assign digit_ok = (bus.digit_in <= 4'd9);
  // Timeout only matters when no enter arrives the same cycle (enter wins)
  assign to_hit   = (state_q != IDLE) && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  // Key path: 2-flop synchronizer, debounce on level change, press = debounced fall
  always_comb begin
    sync1_d   = bus.enter_n;
    sync2_d   = sync1_q;
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) deb_d = sync2_q;
      else                                       deb_cnt_d = deb_cnt_q + 1'b1;
    end
    enter_d = deb_q & ~deb_d;
  end

  // Entry FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (enter_q) state_d = D0;
      D0:   if (enter_q) begin if (digit_ok) state_d = D1; end
            else if (to_hit) state_d = IDLE;
      D1:   if (enter_q) begin if (digit_ok) state_d = D2; end
            else if (to_hit) state_d = IDLE;
      D2:   if (enter_q) begin if (digit_ok) state_d = IDLE; end
            else if (to_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath, pulses, timers and display controls (all registered)
  always_comb begin
    shadow_d  = shadow_q;
    value_d   = value_q;
    valid_d   = 1'b0;
    abort_d   = 1'b0;
    err_d     = 1'b0;
    to_cnt_d  = (state_q == IDLE || enter_q || to_hit) ? '0 : to_cnt_q + 1'b1;
    blk_cnt_d = blk_cnt_q + 1'b1;
    blink_d   = blink_q;
    if (enter_q) begin
      if (state_q == IDLE) shadow_d = '0;
      else if (!digit_ok) err_d = 1'b1;
      else begin
        case (state_q)
          D0:      shadow_d[3:0]  = bus.digit_in;
          D1:      shadow_d[7:4]  = bus.digit_in;
          default: shadow_d[11:8] = bus.digit_in;
        endcase
        if (state_q == D2) begin
          value_d = {bus.digit_in, shadow_q[7:0]};
          valid_d = 1'b1;
        end
      end
    end else if (to_hit) begin
      abort_d  = 1'b1;
      shadow_d = '0;
    end
    // A newly active digit always starts lit
    if (state_d != state_q || state_q == IDLE) begin
      blk_cnt_d = '0;
      blink_d   = 1'b1;
    end else if (blk_cnt_q == BW'(BLINK_HALF - 1)) begin
      blk_cnt_d = '0;
      blink_d   = ~blink_q;
    end
    disp_d = (state_d != IDLE);
    case (state_d)
      IDLE:    seg_d = 4'b0111;
      D0:      seg_d = {3'b100, blink_d};
      D1:      seg_d = {2'b10, blink_d, 1'b1};
      default: seg_d = {1'b1, blink_d, 2'b11};
    endcase
  end

  // State and output registers
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      deb_q     <= 1'b1;
      deb_cnt_q <= '0;
      enter_q   <= 1'b0;
      state_q   <= IDLE;
      to_cnt_q  <= '0;
      blk_cnt_q <= '0;
      blink_q   <= 1'b1;
      shadow_q  <= '0;
      value_q   <= '0;
      valid_q   <= 1'b0;
      abort_q   <= 1'b0;
      err_q     <= 1'b0;
      disp_q    <= 1'b0;
      seg_q     <= 4'b0111;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
      enter_q   <= enter_d;
      state_q   <= state_d;
      to_cnt_q  <= to_cnt_d;
      blk_cnt_q <= blk_cnt_d;
      blink_q   <= blink_d;
      shadow_q  <= shadow_d;
      value_q   <= value_d;
      valid_q   <= valid_d;
      abort_q   <= abort_d;
      err_q     <= err_d;
      disp_q    <= disp_d;
      seg_q     <= seg_d;
    end
  end

  assign bus.value_out   = value_q;
  assign bus.shadow_out  = shadow_q;
  assign bus.value_valid = valid_q;
  assign bus.abort       = abort_q;
  assign bus.digit_err   = err_q;
  assign bus.input_state = state_q;
  assign bus.disp_mode   = disp_q;
  assign bus.seg_en      = seg_q;
endmodule

// File: doc/bcd_entry_ctrl.md
Name: bcd_entry_ctrl

Overview:
Sequences three-digit BCD entry from the slide switches and the enter push-button. It owns the entry state machine, debounce and edge detection for the enter key, the shadow and committed value registers, and the display-mode and seven-segment enable controls. It sits between the board inputs (KEY[3], SW[3:0]) and the display datapath (BCD-to-7-segment decoders on HEX0..HEX3). The top level instantiates it in place of ad-hoc entry logic.

Parameters:
DEBOUNCE_CYCLES, 500000, stable cycles required on the enter key before a level change is accepted (10 ms at 50 MHz); benches override to 4.
BLINK_HALF, 12500000, cycles per half-period of the edit-digit blink (0.25 s); benches override to 8.
TIMEOUT_CYCLES, 500000000, idle cycles in any entry state before entry aborts (10 s); benches override to 200.

Ports:
CLOCK_50  in  1  system clock, 50 MHz.
RESET_N  in  1  asynchronous active-low reset.
enter_n  in  1  raw enter key, active-low (KEY[3]); asynchronous to CLOCK_50.
digit_in  in  4  BCD digit from SW[3:0].
value_out  out  12  committed value {hundreds, tens, ones}.
shadow_out  out  12  value under entry.
value_valid  out  1  one-cycle pulse on commit.
abort  out  1  one-cycle pulse on timeout abort.
digit_err  out  1  one-cycle pulse when enter is pressed with digit_in > 9.
input_state  out  2  0=IDLE, 1=D0, 2=D1, 3=D2.
disp_mode  out  1  0 = display value_out, 1 = display shadow_out.
seg_en  out  4  per-digit enables for HEX0..HEX3, 1 = lit.

Behaviour:
- Reset (asynchronous, RESET_N=0): state=IDLE; value_out=0; shadow_out=0; all pulses=0; disp_mode=0; seg_en=4'b0111; debounce, blink and timeout counters=0; debounced key=released.
- Input path: enter_n passes through a 2-flop synchronizer, then a debounce counter.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive identical synchronized samples.
  - Press = debounced high-to-low transition. It produces a 1-cycle internal enter pulse.
  - Holding the key produces exactly one pulse. Release produces none.
- Enter latency: the enter pulse occurs 2 + DEBOUNCE_CYCLES (±1) cycles after the raw falling edge. The state and shadow update on the cycle after the pulse.
- Entry order is ones, then tens, then hundreds.
- IDLE:
  - enter -> D0.
  - shadow_out cleared to 0 on entry to D0.
  - digit_in is ignored.
- D0, D1, D2, on enter:
  - If digit_in <= 9: latch it into shadow nibble [3:0], [7:4] or [11:8] respectively, and advance D0->D1->D2.
  - From D2, latch [11:8], copy the full shadow (including the new nibble) into value_out the same cycle, pulse value_valid, and return to IDLE.
  - If digit_in > 9: pulse digit_err; state and shadow are unchanged.
- Timeout:
  - The counter clears on every enter pulse (valid or not) and in IDLE. It counts in D0..D2.
  - When it reaches TIMEOUT_CYCLES: pulse abort, go to IDLE. value_out is unchanged and shadow_out is cleared.
  - If an enter pulse and the timeout fall on the same cycle, the enter wins and the counter clears.
- disp_mode is 1 in D0..D2 and 0 in IDLE.
- seg_en in IDLE = 0111 (digits 0-2 lit, HEX3 blank).
- seg_en during entry:
  - Bit 3 = 1 (mode indicator).
  - Already-entered digits = 1.
  - Digit being edited = blink phase.
  - Digits not yet entered = 0.
  - D0: {1,0,0,b}. D1: {1,0,b,1}. D2: {1,b,1,1}.
- Blink:
  - The counter toggles phase b every BLINK_HALF cycles.
  - Counter and b reset to b=1 (lit) on every state change, so a newly active digit starts lit.
- All outputs are registered. The value_valid, abort and digit_err pulses are each exactly 1 cycle and mutually exclusive.
- Reset mid-entry discards the shadow and value_out immediately (asynchronous).
- Unused input_state encodings cannot occur (2-bit full encoding).

Test Plan:
1. Release reset, idle 20 cycles -> input_state=0, disp_mode=0, seg_en=0111, value_out=000.
2. Press enter, then enter digits 3,2,1 with one press each (ones first) -> input_state steps 1,2,3,0; seg_en follows 1001/1000 (blinking), 1011/1001, 1111/1011, then 0111; value_out=12'h123; one value_valid pulse.
3. Repeat with 0x875, then 0x440 -> value_out updates to 875 and then 440. A 0 digit is accepted and the last commit wins.
4. Hold enter_n low for 10*DEBOUNCE_CYCLES, plus a bounce of 2-cycle glitches before the press -> exactly one state advance.
5. In D1, set digit_in=4'hA and press -> digit_err pulses once, state stays 2, shadow unchanged; then digit_in=7 and press -> advances to D2 with shadow[7:4]=7.
6. Enter D0 and one digit, then wait TIMEOUT_CYCLES -> abort pulses, state=0, value_out keeps its prior value, shadow=0. Also assert RESET_N low in D2 -> all outputs return to reset values asynchronously.
